// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer:
// FSM states, CSR addresses, privilege encodings, cause codes and mstatus update helpers.
package trap_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    W_EPC       = 3'd1,
    W_CAUSE     = 3'd2,
    W_STATUS    = 3'd3,
    MRET_STATUS = 3'd4,
    REDIRECT    = 3'd5
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [1:0] MMODE = 2'b11;
  localparam logic [1:0] UMODE = 2'b00;

  localparam logic [3:0] CAUSE_ECALL_U = 4'd8;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;
  localparam logic [3:0] CAUSE_MEI     = 4'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Trap entry: stack MIE into MPIE, mask interrupts, remember the trapping mode.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms,
                                                   input logic [1:0] priv);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = UMODE;
    return r;
  endfunction

endpackage

// File: rtl/trap_target_calc.sv
// Trap vector target: direct mode (or any exception) jumps to the base,
// vectored mode sends interrupts to base + 4*cause.
module trap_target_calc
  import trap_pkg::*;
(
  input  logic [XLEN-1:0] mtvec,
  input  logic            is_irq,
  input  logic [3:0]      cause,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] base_s;

  // Select direct or vectored target.
  always_comb begin
    base_s = {mtvec[XLEN-1:2], 2'b00};
    if ((mtvec[1:0] == 2'b00) || !is_irq) begin
      target = base_s;
    end else begin
      target = base_s + {{(XLEN-6){1'b0}}, cause, 2'b00};
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: stalls the pipeline, walks the CSR write port through
// the trap-entry or mret updates, then redirects the PC and flushes.
module trap_controller
  import trap_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_exceptionFromInst,
  input  logic [3:0]      i_causeFromInst,
  input  logic            i_mret,
  input  logic            i_irqExternal,
  input  logic            i_irqTimer,
  input  logic [XLEN-1:0] i_mstatus,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  input  logic            i_mieMEIE,
  input  logic            i_mieMTIE,
  output logic            o_stall,
  output logic            o_flush,
  output logic            o_pcRedirect,
  output logic [XLEN-1:0] o_redirectPc,
  output logic            o_csrWe,
  output logic [11:0]     o_csrAddr,
  output logic [XLEN-1:0] o_csrWdata,
  output logic [1:0]      o_privMode
);

  state_t          state_r;
  logic [XLEN-1:0] epc_r;
  logic [3:0]      cause_r;
  logic            is_irq_r;
  logic [1:0]      priv_r;
  logic            flush_r;
  logic            redirect_r;
  logic [XLEN-1:0] redirect_pc_r;
  logic            csr_we_r;
  logic [11:0]     csr_addr_r;
  logic [XLEN-1:0] csr_wdata_r;

  logic            irq_en_s;
  logic            ext_s;
  logic            tmr_s;
  logic            trap_s;
  logic            accept_s;
  logic [3:0]      sel_cause_s;
  logic            sel_irq_s;
  logic [XLEN-1:0] target_s;

  // Event qualification and fixed-priority cause selection.
  always_comb begin
    irq_en_s = (priv_r == UMODE) || i_mstatus[MSTATUS_MIE];
    ext_s    = i_irqExternal & i_mieMEIE & irq_en_s;
    tmr_s    = i_irqTimer & i_mieMTIE & irq_en_s;
    trap_s   = i_exceptionFromInst | ext_s | tmr_s;
    accept_s = (state_r == IDLE) && i_valid && (trap_s || i_mret);
    if (i_exceptionFromInst) begin
      // An ecall raised in M-mode reports the M-mode ecall cause.
      if ((i_causeFromInst == CAUSE_ECALL_U) && (priv_r == MMODE)) begin
        sel_cause_s = CAUSE_ECALL_M;
      end else begin
        sel_cause_s = i_causeFromInst;
      end
      sel_irq_s = 1'b0;
    end else if (ext_s) begin
      sel_cause_s = CAUSE_MEI;
      sel_irq_s   = 1'b1;
    end else if (tmr_s) begin
      sel_cause_s = CAUSE_MTI;
      sel_irq_s   = 1'b1;
    end else begin
      sel_cause_s = 4'd0;
      sel_irq_s   = 1'b0;
    end
    o_stall = (state_r != IDLE) || accept_s;
  end

  trap_target_calc u_target (
    .mtvec  (i_mtvec),
    .is_irq (is_irq_r),
    .cause  (cause_r),
    .target (target_s)
  );

  // Sequencer: each state presets the CSR write presented in the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= IDLE;
      epc_r         <= {XLEN{1'b0}};
      cause_r       <= 4'd0;
      is_irq_r      <= 1'b0;
      priv_r        <= MMODE;
      flush_r       <= 1'b0;
      redirect_r    <= 1'b0;
      redirect_pc_r <= {XLEN{1'b0}};
      csr_we_r      <= 1'b0;
      csr_addr_r    <= 12'h000;
      csr_wdata_r   <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          flush_r    <= 1'b0;
          redirect_r <= 1'b0;
          if (accept_s) begin
            epc_r    <= i_mepc;
            cause_r  <= sel_cause_s;
            is_irq_r <= sel_irq_s;
            csr_we_r <= 1'b1;
            if (trap_s) begin
              state_r     <= W_EPC;
              csr_addr_r  <= CSR_MEPC;
              csr_wdata_r <= i_pc & {{(XLEN-2){1'b1}}, 2'b00};
            end else begin
              state_r     <= MRET_STATUS;
              csr_addr_r  <= CSR_MSTATUS;
              csr_wdata_r <= mret_mstatus(i_mstatus);
            end
          end else begin
            csr_we_r <= 1'b0;
          end
        end
        W_EPC: begin
          state_r     <= W_CAUSE;
          csr_addr_r  <= CSR_MCAUSE;
          csr_wdata_r <= {is_irq_r, {(XLEN-5){1'b0}}, cause_r};
        end
        W_CAUSE: begin
          state_r     <= W_STATUS;
          csr_addr_r  <= CSR_MSTATUS;
          csr_wdata_r <= trap_mstatus(i_mstatus, priv_r);
        end
        W_STATUS: begin
          state_r       <= REDIRECT;
          csr_we_r      <= 1'b0;
          priv_r        <= MMODE;
          flush_r       <= 1'b1;
          redirect_r    <= 1'b1;
          redirect_pc_r <= target_s;
        end
        MRET_STATUS: begin
          state_r       <= REDIRECT;
          csr_we_r      <= 1'b0;
          priv_r        <= i_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
          flush_r       <= 1'b1;
          redirect_r    <= 1'b1;
          redirect_pc_r <= epc_r;
        end
        REDIRECT: begin
          state_r    <= IDLE;
          flush_r    <= 1'b0;
          redirect_r <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          csr_we_r   <= 1'b0;
          flush_r    <= 1'b0;
          redirect_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_flush      = flush_r;
  assign o_pcRedirect = redirect_r;
  assign o_redirectPc = redirect_pc_r;
  assign o_csrWe      = csr_we_r;
  assign o_csrAddr    = csr_addr_r;
  assign o_csrWdata   = csr_wdata_r;
  assign o_privMode   = priv_r;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: stimulus queues expected CSR writes and
// redirects with their cycle numbers; a negedge monitor pops and compares.
module tb_trap_controller;
  import trap_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [31:0] i_pc;
  logic        i_exceptionFromInst;
  logic [3:0]  i_causeFromInst;
  logic        i_mret;
  logic        i_irqExternal;
  logic        i_irqTimer;
  logic [31:0] i_mstatus;
  logic [31:0] i_mtvec;
  logic [31:0] i_mepc;
  logic        i_mieMEIE;
  logic        i_mieMTIE;
  logic        o_stall;
  logic        o_flush;
  logic        o_pcRedirect;
  logic [31:0] o_redirectPc;
  logic        o_csrWe;
  logic [11:0] o_csrAddr;
  logic [31:0] o_csrWdata;
  logic [1:0]  o_privMode;

  trap_controller dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_valid             (i_valid),
    .i_pc                (i_pc),
    .i_exceptionFromInst (i_exceptionFromInst),
    .i_causeFromInst     (i_causeFromInst),
    .i_mret              (i_mret),
    .i_irqExternal       (i_irqExternal),
    .i_irqTimer          (i_irqTimer),
    .i_mstatus           (i_mstatus),
    .i_mtvec             (i_mtvec),
    .i_mepc              (i_mepc),
    .i_mieMEIE           (i_mieMEIE),
    .i_mieMTIE           (i_mieMTIE),
    .o_stall             (o_stall),
    .o_flush             (o_flush),
    .o_pcRedirect        (o_pcRedirect),
    .o_redirectPc        (o_redirectPc),
    .o_csrWe             (o_csrWe),
    .o_csrAddr           (o_csrAddr),
    .o_csrWdata          (o_csrWdata),
    .o_privMode          (o_privMode)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    int          at;
  } csr_item_t;

  typedef struct {
    logic [31:0] pc;
    int          at;
  } rd_item_t;

  csr_item_t csr_q[$];
  rd_item_t  rd_q[$];
  csr_item_t mon_csr;
  rd_item_t  mon_rd;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every CSR write or redirect must match the head of its queue.
  always @(negedge i_clk) begin
    if (o_csrWe) begin
      if (csr_q.size() == 0) begin
        check("unexpected csr write addr", {20'h0, o_csrAddr}, 32'h0);
      end else begin
        mon_csr = csr_q.pop_front();
        check("csr addr", {20'h0, o_csrAddr}, {20'h0, mon_csr.addr});
        check("csr data", o_csrWdata, mon_csr.data);
        check("csr cycle", cyc, mon_csr.at);
      end
    end
    if (o_pcRedirect || o_flush) begin
      if (rd_q.size() == 0) begin
        check("unexpected redirect pc", o_redirectPc, 32'h0);
      end else begin
        mon_rd = rd_q.pop_front();
        check("redirect pc", o_redirectPc, mon_rd.pc);
        check("redirect cycle", cyc, mon_rd.at);
        check("flush with redirect", {30'h0, o_flush, o_pcRedirect}, 32'h3);
      end
    end
  end

  task automatic clear_inputs();
    i_valid = 1'b0;
    i_exceptionFromInst = 1'b0;
    i_causeFromInst = 4'd0;
    i_mret = 1'b0;
  endtask

  task automatic expect_trap(input int t, input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] status, input logic [31:0] target);
    csr_q.push_back('{CSR_MEPC, epc, t + 1});
    csr_q.push_back('{CSR_MCAUSE, cause, t + 2});
    csr_q.push_back('{CSR_MSTATUS, status, t + 3});
    rd_q.push_back('{target, t + 4});
  endtask

  task automatic expect_mret(input int t, input logic [31:0] status, input logic [31:0] target);
    csr_q.push_back('{CSR_MSTATUS, status, t + 1});
    rd_q.push_back('{target, t + 2});
  endtask

  // Called at a negedge with the event driven; counts stall cycles (bounded).
  task automatic run_seq(input string name, input int exp_stall);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (o_stall) n++;
      else done = 1'b1;
      @(negedge i_clk);
      if (k == 0) clear_inputs();
    end
    check(name, n, exp_stall);
    repeat (2) @(negedge i_clk);
    check({name, " pending"}, csr_q.size() + rd_q.size(), 0);
  endtask

  task automatic do_mret(input logic [31:0] ms, input logic [31:0] epc, input logic [31:0] wr);
    i_mstatus = ms;
    i_mepc = epc;
    i_pc = 32'h0000_0120;
    i_valid = 1'b1;
    i_mret = 1'b1;
    expect_mret(cyc, wr, epc);
    run_seq("mret stall", 3);
    check("priv after mret", {30'h0, o_privMode}, {30'h0, UMODE});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0;
    clear_inputs();
    i_pc = 32'h0;
    i_irqExternal = 1'b0;
    i_irqTimer = 1'b0;
    i_mstatus = 32'h0;
    i_mtvec = 32'h0000_0200;
    i_mepc = 32'h0;
    i_mieMEIE = 1'b0;
    i_mieMTIE = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check("reset priv", {30'h0, o_privMode}, {30'h0, MMODE});
    check("reset stall", {31'h0, o_stall}, 32'h0);
    check("reset csrWe", {31'h0, o_csrWe}, 32'h0);
    check("reset flush", {31'h0, o_flush}, 32'h0);
    check("reset pcRedirect", {31'h0, o_pcRedirect}, 32'h0);
    check("reset csrAddr", {20'h0, o_csrAddr}, 32'h0);
    check("reset csrWdata", o_csrWdata, 32'h0);
    check("reset redirectPc", o_redirectPc, 32'h0);
    @(negedge i_clk);

    // Drop to U-mode: MPIE=1, MPP=00.
    do_mret(32'h0000_0080, 32'h0000_0104, 32'h0000_0088);

    // U-mode ecall, direct mtvec.
    i_mstatus = 32'h0000_0008;
    i_mtvec = 32'h0000_0200;
    i_pc = 32'h0000_0100;
    i_valid = 1'b1;
    i_exceptionFromInst = 1'b1;
    i_causeFromInst = CAUSE_ECALL_U;
    expect_trap(cyc, 32'h0000_0100, 32'h0000_0008, 32'h0000_0080, 32'h0000_0200);
    run_seq("u ecall stall", 5);
    check("priv after u ecall", {30'h0, o_privMode}, {30'h0, MMODE});

    // M-mode ecall reports cause 11 and MPP=11.
    i_pc = 32'h0000_0204;
    i_valid = 1'b1;
    i_exceptionFromInst = 1'b1;
    i_causeFromInst = CAUSE_ECALL_U;
    expect_trap(cyc, 32'h0000_0204, 32'h0000_000B, 32'h0000_1880, 32'h0000_0200);
    run_seq("m ecall stall", 5);

    // Timer in M-mode with MIE=0 is masked: no stall, no writes.
    i_mstatus = 32'h0;
    i_irqTimer = 1'b1;
    i_mieMTIE = 1'b1;
    i_pc = 32'h0000_0208;
    i_valid = 1'b1;
    run_seq("masked timer stall", 0);
    i_irqTimer = 1'b0;

    do_mret(32'h0000_0080, 32'h0000_0300, 32'h0000_0088);

    // Timer in U-mode, vectored mtvec: 0x200 + 4*7.
    i_mstatus = 32'h0000_0008;
    i_mtvec = 32'h0000_0201;
    i_irqTimer = 1'b1;
    i_pc = 32'h0000_0310;
    i_valid = 1'b1;
    expect_trap(cyc, 32'h0000_0310, 32'h8000_0007, 32'h0000_0080, 32'h0000_021C);
    run_seq("u timer stall", 5);
    i_irqTimer = 1'b0;
    check("priv after timer", {30'h0, o_privMode}, {30'h0, MMODE});

    // External irq in M-mode with MIE=1, vectored; misaligned pc gets aligned.
    i_mieMEIE = 1'b1;
    i_irqExternal = 1'b1;
    i_pc = 32'h0000_0402;
    i_valid = 1'b1;
    expect_trap(cyc, 32'h0000_0400, 32'h8000_000B, 32'h0000_1880, 32'h0000_022C);
    run_seq("m ext stall", 5);
    i_irqExternal = 1'b0;
    i_mtvec = 32'h0000_0200;

    do_mret(32'h0000_0080, 32'h0000_0500, 32'h0000_0088);

    // Exception and external irq together: exception wins; reset lands at T+2.
    i_mstatus = 32'h0000_0008;
    i_irqExternal = 1'b1;
    i_pc = 32'h0000_0500;
    i_valid = 1'b1;
    i_exceptionFromInst = 1'b1;
    i_causeFromInst = CAUSE_ILLEGAL;
    csr_q.push_back('{CSR_MEPC, 32'h0000_0500, cyc + 1});
    csr_q.push_back('{CSR_MCAUSE, 32'h0000_0002, cyc + 2});
    #1;
    check("exc+irq accept stall", {31'h0, o_stall}, 32'h1);
    @(negedge i_clk);
    clear_inputs();
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid reset csrWe", {31'h0, o_csrWe}, 32'h0);
    check("mid reset stall", {31'h0, o_stall}, 32'h0);
    check("mid reset flush", {31'h0, o_flush}, 32'h0);
    check("mid reset pcRedirect", {31'h0, o_pcRedirect}, 32'h0);
    check("mid reset priv", {30'h0, o_privMode}, {30'h0, MMODE});
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (4) @(negedge i_clk);
    check("after reset pending", csr_q.size() + rd_q.size(), 0);

    // The still-pending external interrupt is taken at the next commit.
    i_pc = 32'h0000_0504;
    i_valid = 1'b1;
    expect_trap(cyc, 32'h0000_0504, 32'h8000_000B, 32'h0000_1880, 32'h0000_0200);
    run_seq("pending ext stall", 5);
    i_irqExternal = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Multi-cycle machine-mode trap sequencer sitting between the instruction exception decoder, the interrupt lines and the CSR file. On a synchronous exception, a qualified interrupt or an `mret` at commit, it stalls the pipeline and drives the CSR file's single write port through the required CSR updates. It then redirects the PC and flushes the pipeline. It also owns the current privilege-mode register, which feeds back to the exception decoder.

## Interface
- XLEN, 32, datapath / CSR width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_valid  in  1  instruction at commit is valid
- i_pc  in  XLEN  PC of committing instruction
- i_exceptionFromInst  in  1  synchronous exception from decoder
- i_causeFromInst  in  4  exception cause code
- i_mret  in  1  legal mret at commit
- i_irqExternal, i_irqTimer  in  1 each  pending interrupt levels (mip.MEIP, mip.MTIP)
- i_mstatus, i_mtvec, i_mepc  in  XLEN each  current CSR values
- i_mieMEIE, i_mieMTIE  in  1 each  interrupt enables
- o_stall  out  1  hold pipeline
- o_flush  out  1  one-cycle flush pulse
- o_pcRedirect  out  1  one-cycle PC load strobe
- o_redirectPc  out  XLEN  target PC, valid with o_pcRedirect
- o_csrWe  out  1  CSR write strobe
- o_csrAddr  out  12  CSR address
- o_csrWdata  out  XLEN  CSR write data
- o_privMode  out  2  current privilege mode (11=M, 00=U)

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, MRET_STATUS, REDIRECT.
- Interrupts are enabled when o_privMode==U or mstatus.MIE (bit 3)==1.
- Event selection in IDLE applies only when i_valid=1, in fixed priority:
  - i_exceptionFromInst;
  - then external interrupt (i_irqExternal & MEIE & enabled, cause 11);
  - then timer interrupt (i_irqTimer & MTIE & enabled, cause 7);
  - then i_mret.
- On event accept, the block latches i_pc, the cause, and an isIrq flag.
- ecall cause fixup: cause 8 accepted while o_privMode==M is latched as 11.
- Trap sequence:
  - W_EPC: write mepc(0x341) = {latched pc[XLEN-1:2], 2'b00}.
  - W_CAUSE: write mcause(0x342) = {isIrq, zeros, cause[3:0]}.
  - W_STATUS: write mstatus(0x300) = i_mstatus with MPIE(7)←MIE(3), MIE←0, MPP(12:11)←o_privMode. o_privMode←M at the end of this cycle.
  - REDIRECT: target = {mtvec[XLEN-1:2],00} when mtvec[1:0]==00 or !isIrq; otherwise base + 4·cause.
- mret sequence:
  - MRET_STATUS: write mstatus with MIE←MPIE, MPIE←1, MPP←00. o_privMode←old MPP.
  - REDIRECT: target = i_mepc latched at accept.
- REDIRECT asserts o_pcRedirect=1 and o_flush=1 for one cycle, then the FSM returns to IDLE.
- Inputs are ignored outside IDLE. CSR values are read live, since no other CSR writer exists while stalled.
- Reset values:
  - state IDLE, o_privMode=M;
  - o_stall, o_flush, o_pcRedirect, o_csrWe = 0;
  - o_csrAddr, o_csrWdata, o_redirectPc = 0.

## Timing
- o_stall is combinational: high in the accept cycle T (IDLE with an event) and in every non-IDLE state, including REDIRECT.
- Trap: mepc write at T+1, mcause at T+2, mstatus at T+3, redirect+flush at T+4. o_stall is high T..T+4 (5 cycles).
- mret: mstatus write at T+1, redirect+flush at T+2.
- o_csrWe is high exactly in the W_* and MRET_STATUS states. Address and data are valid in the same cycle; the CSR file captures them on the following edge.
- Simultaneous exception and interrupt: the exception wins; the interrupt stays pending and is taken at a later commit.
- Reset asserted mid-sequence: the FSM goes to IDLE immediately and all strobes drop. Remaining writes are abandoned, and o_privMode returns to M.
- A second event is never accepted before REDIRECT completes. The first accept is possible the cycle after REDIRECT.

## Structure
- Shared package trap_pkg holds:
  - the state enum;
  - CSR addresses (MSTATUS=0x300, MEPC=0x341, MCAUSE=0x342);
  - privilege encodings (MMODE=2'b11, UMODE=2'b00);
  - cause codes (ECALL_U=8, ECALL_M=11, ILLEGAL=2, MTI=7, MEI=11);
  - mstatus bit positions.
- One sub-module, trap_target_calc: combinational mtvec direct/vectored target computation.

## Test plan
- U-mode ecall (i_exceptionFromInst=1, cause 8, pc=0x100, mtvec=0x200, mstatus.MIE=1) -> writes mepc=0x100, mcause=8, then mstatus MIE=0/MPIE=1/MPP=00; redirect to 0x200 at T+4; o_privMode=M.
- M-mode ecall -> mcause=11 written.
- Timer interrupt in U-mode with MTIE=1, vectored mtvec=0x201 -> mcause=0x80000007; redirect to 0x21C.
- Same interrupt in M-mode with MIE=0 -> no stall, no writes.
- mret with mstatus MPIE=1, MPP=00, mepc=0x104 -> mstatus write MIE=1/MPIE=1/MPP=00; redirect to 0x104 at T+2; o_privMode=U.
- Exception plus external interrupt in the same cycle -> exception cause written. Then reset asserted at T+2 -> all outputs 0, o_privMode=M, no mstatus write.
